// File: rtl/jtag_uart_pkg.sv
// Shared types and constants for the JTAG UART transmit drain.
// The state enum and debug struct are shared so checkers can bind to them.
package jtag_uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_POLL    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_BACKOFF = 2'd3
   } state_t;

   localparam logic        DATA_ADDR  = 1'b0;
   localparam logic        CTRL_ADDR  = 1'b1;
   localparam logic [31:0] CTRL_VALUE = 32'd2;
   localparam int          WSPACE_HI  = 31;
   localparam int          WSPACE_LO  = 16;
   localparam int          ENTRY_W    = 9;

   typedef struct packed {
      state_t      state;
      logic [15:0] fifo_count;
      logic [15:0] credit;
   } dbg_t;

   function automatic logic is_ctrl(input logic [ENTRY_W-1:0] entry);
      return entry[8];
   endfunction

endpackage

// File: rtl/jtag_uart_tx_drain_if.sv
// Processor push port plus Avalon-MM master bus of the transmit drain.
interface jtag_uart_tx_drain_if;

   // A push is accepted on an edge with proc_oEn=1 and proc_iBusy=0; a bus
   // transfer completes on an edge with avm_chipselect=1 and avm_waitrequest=0.
   logic        proc_oEn;
   logic [15:0] proc_oData;
   logic        proc_iBusy;
   logic        overflow;
   logic        avm_chipselect;
   logic        avm_address;
   logic        avm_read_n;
   logic        avm_write_n;
   logic [31:0] avm_writedata;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   modport master (
      input  proc_oEn, proc_oData, avm_readdata, avm_waitrequest,
      output proc_iBusy, overflow, avm_chipselect, avm_address,
             avm_read_n, avm_write_n, avm_writedata
   );

   modport slave (
      output proc_oEn, proc_oData, avm_readdata, avm_waitrequest,
      input  proc_iBusy, overflow, avm_chipselect, avm_address,
             avm_read_n, avm_write_n, avm_writedata
   );

endinterface

// File: rtl/jtag_tx_fifo.sv
// Synchronous FIFO of output entries; full/empty are registered alongside count.
module jtag_tx_fifo
   import jtag_uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rstn,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [ENTRY_W-1:0]       i_data,
   output logic [ENTRY_W-1:0]       o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [ENTRY_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_wr_ptr;
   logic [AW-1:0]      r_rd_ptr;
   logic [AW:0]        r_count;
   logic               r_full;
   logic               r_empty;
   logic               w_push;
   logic               w_pop;
   logic [AW:0]        w_count_nxt;

   // A write while full is dropped even if a pop happens on the same edge.
   assign w_push = i_push && !r_full;
   assign w_pop  = i_pop && !r_empty;

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)
         w_count_nxt = r_count + (AW+1)'(1);
      else if (!w_push && w_pop)
         w_count_nxt = r_count - (AW+1)'(1);
   end

   always_ff @(posedge i_clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == FULL_CNT);
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_head  = r_mem[r_rd_ptr];
   assign o_full  = r_full;
   assign o_empty = r_empty;
   assign o_count = r_count;

endmodule

// File: rtl/jtag_uart_tx_drain.sv
// Buffers processor output and drains it to the JTAG UART over Avalon-MM,
// polling WSPACE for write credit before sending characters.
module jtag_uart_tx_drain
   import jtag_uart_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int POLL_GAP = 64
) (
   input  logic                        system1000,
   input  logic                        system1000_rstn,
   jtag_uart_tx_drain_if.master        bus,
   output dbg_t                        o_dbg
);

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

   state_t               r_state;
   logic                 r_cs;
   logic                 r_read_n;
   logic                 r_write_n;
   logic                 r_addr;
   logic [31:0]          r_wdata;
   logic [15:0]          r_credit;
   logic [GW-1:0]        r_gap;
   logic                 r_overflow;

   logic [ENTRY_W-1:0]   w_head;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_pop;
   logic [15:0]          w_wspace;
   logic [$clog2(DEPTH):0] w_count;
   logic                 w_unused;

   assign w_pop    = (r_state == ST_WRITE) && !bus.avm_waitrequest;
   assign w_wspace = bus.avm_readdata[WSPACE_HI:WSPACE_LO];
   assign w_unused = ^{bus.proc_oData[15:9], bus.avm_readdata[WSPACE_LO-1:0]};

   jtag_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk   (system1000),
      .i_rstn  (system1000_rstn),
      .i_push  (bus.proc_oEn),
      .i_pop   (w_pop),
      .i_data  (bus.proc_oData[ENTRY_W-1:0]),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge system1000) begin
      if (!system1000_rstn) begin
         r_state    <= ST_IDLE;
         r_cs       <= 1'b0;
         r_read_n   <= 1'b1;
         r_write_n  <= 1'b1;
         r_addr     <= DATA_ADDR;
         r_wdata    <= '0;
         r_credit   <= '0;
         r_gap      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (bus.proc_oEn && w_full)
            r_overflow <= 1'b1;
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  if (is_ctrl(w_head)) begin
                     r_state   <= ST_WRITE;
                     r_cs      <= 1'b1;
                     r_write_n <= 1'b0;
                     r_addr    <= CTRL_ADDR;
                     r_wdata   <= CTRL_VALUE;
                  end else if (r_credit != '0) begin
                     r_state   <= ST_WRITE;
                     r_cs      <= 1'b1;
                     r_write_n <= 1'b0;
                     r_addr    <= DATA_ADDR;
                     r_wdata   <= {24'd0, w_head[7:0]};
                  end else begin
                     r_state  <= ST_POLL;
                     r_cs     <= 1'b1;
                     r_read_n <= 1'b0;
                     r_addr   <= CTRL_ADDR;
                  end
               end
            end
            ST_POLL: begin
               if (!bus.avm_waitrequest) begin
                  r_credit <= w_wspace;
                  r_cs     <= 1'b0;
                  r_read_n <= 1'b1;
                  if (w_wspace != '0) begin
                     r_state <= ST_IDLE;
                  end else begin
                     r_state <= ST_BACKOFF;
                     r_gap   <= '0;
                  end
               end
            end
            ST_WRITE: begin
               if (!bus.avm_waitrequest) begin
                  r_cs      <= 1'b0;
                  r_write_n <= 1'b1;
                  r_state   <= ST_IDLE;
                  if (!is_ctrl(w_head) && (r_credit != '0))
                     r_credit <= r_credit - 16'd1;
               end
            end
            ST_BACKOFF: begin
               // Bus stays idle for exactly POLL_GAP cycles before the next poll.
               if (r_gap == GW'(POLL_GAP - 1)) begin
                  r_state  <= ST_POLL;
                  r_cs     <= 1'b1;
                  r_read_n <= 1'b0;
                  r_addr   <= CTRL_ADDR;
               end else begin
                  r_gap <= r_gap + GW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.avm_chipselect = r_cs;
   assign bus.avm_read_n     = r_read_n;
   assign bus.avm_write_n    = r_write_n;
   assign bus.avm_address    = r_addr;
   assign bus.avm_writedata  = r_wdata;
   assign bus.overflow       = r_overflow;
   assign bus.proc_iBusy     = w_full;

   assign o_dbg = {r_state, 16'(w_count), r_credit};

endmodule
